signal_mixer_seq: RTL and testbench

SIGNAL_MIXER_SEQ -- requirements
Module: signal_mixer_seq

---
 rtl/signal_mixer_seq.sv | 107 ++++++++++
 tb/tb_signal_mixer_seq.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/signal_mixer_seq.sv
// Sequential channel mixer: sums enabled channels one per cycle, attenuates by a
// right shift and saturates the result to the sample width.
module signal_mixer_seq #(
  parameter  int NUM_CH = 12,
  parameter  int WIDTH  = 8,
  localparam int ACC_W  = WIDTH + $clog2(NUM_CH),
  localparam int SH_W   = $clog2(ACC_W)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH*WIDTH-1:0] samples,
  input  logic [NUM_CH-1:0]       sample_enable,
  input  logic [SH_W-1:0]         shift,
  input  logic                    start,
  output logic                    busy,
  output logic [WIDTH-1:0]        sample_out,
  output logic                    out_valid,
  output logic                    clip,
  output logic                    overrun
);

  localparam int IDX_W = $clog2(NUM_CH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t                  state;
  state_t                  state_next;
  logic [IDX_W-1:0]        idx;
  logic [ACC_W-1:0]        acc;
  logic [NUM_CH*WIDTH-1:0] snap_samples;
  logic [NUM_CH-1:0]       snap_en;
  logic [SH_W-1:0]         snap_shift;
  logic [WIDTH-1:0]        cur_sample;
  logic [ACC_W-1:0]        shifted;
  logic                    saturate;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = ACCUM;
      ACCUM:   if (idx == LAST_IDX) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  // Disabled channels contribute zero; a shift of ACC_W or more naturally yields zero.
  always_comb begin
    cur_sample = snap_en[idx] ? snap_samples[int'(idx)*WIDTH +: WIDTH] : '0;
    shifted    = acc >> snap_shift;
    saturate   = |shifted[ACC_W-1:WIDTH];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx          <= '0;
      acc          <= '0;
      snap_samples <= '0;
      snap_en      <= '0;
      snap_shift   <= '0;
      sample_out   <= '0;
      out_valid    <= 1'b0;
      clip         <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      overrun   <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            snap_samples <= samples;
            snap_en      <= sample_enable;
            snap_shift   <= shift;
            acc          <= '0;
            idx          <= '0;
          end
        end
        ACCUM: begin
          acc     <= acc + {{(ACC_W-WIDTH){1'b0}}, cur_sample};
          idx     <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
          overrun <= start;
        end
        DONE: begin
          sample_out <= saturate ? {WIDTH{1'b1}} : shifted[WIDTH-1:0];
          clip       <= saturate;
          out_valid  <= 1'b1;
          overrun    <= start;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_signal_mixer_seq.sv
// Directed self-checking bench for signal_mixer_seq at default parameters:
// reset behaviour, mixing, saturation, shift, overrun and mid-mix abort.
module tb_signal_mixer_seq;

  localparam int NUM_CH = 12;
  localparam int WIDTH  = 8;
  localparam int SH_W   = 4;

  logic                    clk;
  logic                    rst;
  logic [NUM_CH*WIDTH-1:0] samples;
  logic [NUM_CH-1:0]       sample_enable;
  logic [SH_W-1:0]         shift;
  logic                    start;
  logic                    busy;
  logic [WIDTH-1:0]        sample_out;
  logic                    out_valid;
  logic                    clip;
  logic                    overrun;

  int checks = 0;
  int errors = 0;

  signal_mixer_seq #(.NUM_CH(NUM_CH), .WIDTH(WIDTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .samples       (samples),
    .sample_enable (sample_enable),
    .shift         (shift),
    .start         (start),
    .busy          (busy),
    .sample_out    (sample_out),
    .out_valid     (out_valid),
    .clip          (clip),
    .overrun       (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [NUM_CH*WIDTH-1:0] fill(input logic [WIDTH-1:0] v);
    logic [NUM_CH*WIDTH-1:0] r;
    for (int i = 0; i < NUM_CH; i++) r[i*WIDTH +: WIDTH] = v;
    return r;
  endfunction

  // Outputs are sampled 1ns after the rising edge so registered values have settled.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [NUM_CH*WIDTH-1:0] s, input logic [NUM_CH-1:0] en,
                               input logic [SH_W-1:0] sh, input logic st);
    samples       = s;
    sample_enable = en;
    shift         = sh;
    start         = st;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
  endtask

  // Expects start already high; the next edge is E0 and the result appears at E0+NUM_CH+1.
  task automatic runMix(input string tag, input logic [WIDTH-1:0] exp_out, input logic exp_clip);
    int early_valid;
    int busy_low;
    early_valid = 0;
    busy_low    = 0;
    step();
    start = 1'b0;
    checkOutput({tag, " busy@E0"}, busy, 1);
    for (int k = 1; k <= NUM_CH; k++) begin
      step();
      if (out_valid !== 1'b0) early_valid++;
      if (busy !== 1'b1) busy_low++;
    end
    checkOutput({tag, " early out_valid"}, early_valid, 0);
    checkOutput({tag, " busy dropped"}, busy_low, 0);
    step();
    checkOutput({tag, " out_valid@E13"}, out_valid, 1);
    checkOutput({tag, " sample_out"}, sample_out, exp_out);
    checkOutput({tag, " clip"}, clip, exp_clip);
    checkOutput({tag, " busy@E13"}, busy, 0);
    step();
    checkOutput({tag, " out_valid@E14"}, out_valid, 0);
    checkOutput({tag, " sample_out held"}, sample_out, exp_out);
    checkOutput({tag, " clip held"}, clip, exp_clip);
  endtask

  initial begin
    logic [NUM_CH*WIDTH-1:0] vec;
    int extra_overrun;
    int early_valid;

    rst = 1'b1;
    applyStimulus(fill(8'd10), '1, 4'd0, 1'b1);
    step();
    step();
    checkOutput("reset busy", busy, 0);
    checkOutput("reset sample_out", sample_out, 0);
    checkOutput("reset out_valid", out_valid, 0);
    checkOutput("reset clip", clip, 0);
    checkOutput("reset overrun", overrun, 0);
    rst   = 1'b0;
    start = 1'b0;
    step();
    step();
    checkOutput("post-reset busy", busy, 0);
    checkOutput("post-reset out_valid", out_valid, 0);

    $display("[TB] mixing all channels at 10");
    applyStimulus(fill(8'd10), '1, 4'd0, 1'b1);
    runMix("all10", 8'd120, 1'b0);

    applyStimulus(fill(8'd255), '1, 4'd0, 1'b1);
    runMix("all255 sh0", 8'd255, 1'b1);

    applyStimulus(fill(8'd255), '1, 4'd4, 1'b1);
    runMix("all255 sh4", 8'd191, 1'b0);

    vec = fill(8'd50);
    vec[0 +: WIDTH]       = 8'd200;
    vec[2*WIDTH +: WIDTH] = 8'd100;
    applyStimulus(vec, 12'h005, 4'd0, 1'b1);
    runMix("en005", 8'd255, 1'b1);

    applyStimulus(fill(8'd77), 12'h000, 4'd0, 1'b1);
    runMix("en000", 8'd0, 1'b0);

    applyStimulus(fill(8'd255), '1, 4'd12, 1'b1);
    runMix("shift12", 8'd0, 1'b0);

    $display("[TB] input change and start during mix");
    applyStimulus(fill(8'd10), '1, 4'd0, 1'b1);
    step();
    start         = 1'b0;
    extra_overrun = 0;
    early_valid   = 0;
    for (int k = 1; k <= NUM_CH; k++) begin
      step();
      if (out_valid !== 1'b0) early_valid++;
      if (k == 1) samples = fill(8'd0);
      if (k == 4) start = 1'b1;
      if (k == 5) begin
        checkOutput("overrun@E5", overrun, 1);
        start = 1'b0;
      end else if (overrun !== 1'b0) begin
        extra_overrun++;
      end
    end
    checkOutput("overrun extra pulses", extra_overrun, 0);
    checkOutput("overrun early out_valid", early_valid, 0);
    step();
    checkOutput("overrun out_valid@E13", out_valid, 1);
    checkOutput("overrun sample_out", sample_out, 120);
    step();
    checkOutput("overrun out_valid@E14", out_valid, 0);
    checkOutput("overrun no restart", busy, 0);

    $display("[TB] reset in the middle of a mix");
    applyStimulus(fill(8'd7), '1, 4'd0, 1'b1);
    step();
    start = 1'b0;
    for (int k = 1; k <= 5; k++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkOutput("abort busy", busy, 0);
    checkOutput("abort sample_out", sample_out, 0);
    checkOutput("abort out_valid", out_valid, 0);
    step();
    checkOutput("abort out_valid@E7", out_valid, 0);
    applyStimulus(fill(8'd5), '1, 4'd0, 1'b1);
    runMix("after abort", 8'd60, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
